mem_access_arbiter: RTL and testbench

//  Shares the single-port byte memory between three requesters: instruction fetch (IF), data access (DA, used for

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_select.sv | 26 ++
 rtl/mem_access_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory access arbiter: FSM states,
// requester IDs and the default burst lock limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_IF   = 2'd1;
    localparam logic [1:0] ID_DA   = 2'd2;
    localparam logic [1:0] ID_DBG  = 2'd3;

    localparam int unsigned LOCK_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection: DBG has absolute priority, IF and DA share
// round-robin against the last IF/DA grant.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_da_req,
    input  logic       i_dbg_req,
    input  logic [1:0] i_rr_last,
    output logic [1:0] o_winner
);

    always_comb begin
        o_winner = ID_NONE;
        if (i_dbg_req) begin
            o_winner = ID_DBG;
        end else if (i_if_req && i_da_req) begin
            o_winner = (i_rr_last == ID_IF) ? ID_DA : ID_IF;
        end else if (i_if_req) begin
            o_winner = ID_IF;
        end else if (i_da_req) begin
            o_winner = ID_DA;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares a single-port byte memory between IF, DA and DBG requesters, turning
// req/ack handshakes into Mem_CS/Mem_WR cycles with support for locked bursts.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic              i_if_lock,
    input  logic              i_if_we,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic [DATA_W-1:0] i_if_wdata,
    output logic              o_if_ack,
    input  logic              i_da_req,
    input  logic              i_da_lock,
    input  logic              i_da_we,
    input  logic [ADDR_W-1:0] i_da_addr,
    input  logic [DATA_W-1:0] i_da_wdata,
    output logic              o_da_ack,
    input  logic              i_dbg_req,
    input  logic              i_dbg_lock,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_ack,
    output logic [DATA_W-1:0] o_arb_rdata,
    output logic [1:0]        o_arb_grant_id,
    output logic              o_arb_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_cs,
    output logic              o_mem_wr
);

    localparam int unsigned      CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    arb_state_e        r_state, w_state_d;
    logic [1:0]        r_grant, w_grant_d;
    logic [1:0]        r_rr_last, w_rr_last_d;
    logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_d;
    logic              r_we, w_we_d;
    logic [ADDR_W-1:0] r_mem_addr, w_addr_d;
    logic [DATA_W-1:0] r_mem_wdata, w_wdata_d;
    logic [DATA_W-1:0] r_rdata, w_rdata_d;
    logic              r_mem_cs, w_cs_d;
    logic              r_mem_wr, w_wr_d;
    logic [2:0]        r_ack, w_ack_d;
    logic              r_busy;

    logic [1:0]        w_winner;
    logic [1:0]        w_pick_id;
    logic              w_pick_req, w_pick_lock, w_pick_we;
    logic [ADDR_W-1:0] w_pick_addr;
    logic [DATA_W-1:0] w_pick_wdata;

    mem_arb_select u_select (
        .i_if_req  (i_if_req),
        .i_da_req  (i_da_req),
        .i_dbg_req (i_dbg_req),
        .i_rr_last (r_rr_last),
        .o_winner  (w_winner)
    );

    // In RESP only the current owner may continue; elsewhere the arbitration winner is examined.
    always_comb begin
        w_pick_id    = (r_state == RESP) ? r_grant : w_winner;
        w_pick_req   = 1'b0;
        w_pick_lock  = 1'b0;
        w_pick_we    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        case (w_pick_id)
            ID_IF: begin
                w_pick_req   = i_if_req;
                w_pick_lock  = i_if_lock;
                w_pick_we    = i_if_we;
                w_pick_addr  = i_if_addr;
                w_pick_wdata = i_if_wdata;
            end
            ID_DA: begin
                w_pick_req   = i_da_req;
                w_pick_lock  = i_da_lock;
                w_pick_we    = i_da_we;
                w_pick_addr  = i_da_addr;
                w_pick_wdata = i_da_wdata;
            end
            ID_DBG: begin
                w_pick_req   = i_dbg_req;
                w_pick_lock  = i_dbg_lock;
                w_pick_we    = i_dbg_we;
                w_pick_addr  = i_dbg_addr;
                w_pick_wdata = i_dbg_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_grant_d    = r_grant;
        w_rr_last_d  = r_rr_last;
        w_lock_cnt_d = r_lock_cnt;
        w_we_d       = r_we;
        w_addr_d     = r_mem_addr;
        w_wdata_d    = r_mem_wdata;
        w_rdata_d    = r_rdata;
        w_cs_d       = 1'b1;
        w_wr_d       = 1'b0;
        w_ack_d      = 3'b000;
        unique case (r_state)
            IDLE: begin
                if (w_pick_id != ID_NONE) begin
                    w_state_d    = ACCESS;
                    w_grant_d    = w_pick_id;
                    w_lock_cnt_d = CNT_W'(1);
                    w_we_d       = w_pick_we;
                    w_addr_d     = w_pick_addr;
                    w_wdata_d    = w_pick_wdata;
                    w_cs_d       = 1'b0;
                    w_wr_d       = w_pick_we;
                    if (w_pick_id != ID_DBG) w_rr_last_d = w_pick_id;
                end
            end
            ACCESS: begin
                w_state_d = RESP;
                w_ack_d   = {r_grant == ID_DBG, r_grant == ID_DA, r_grant == ID_IF};
            end
            RESP: begin
                if (!r_we) w_rdata_d = i_mem_rdata;
                if (w_pick_req && w_pick_lock && (r_lock_cnt < LOCK_MAX_C)) begin
                    w_state_d    = ACCESS;
                    w_lock_cnt_d = r_lock_cnt + CNT_W'(1);
                    w_we_d       = w_pick_we;
                    w_addr_d     = w_pick_addr;
                    w_wdata_d    = w_pick_wdata;
                    w_cs_d       = 1'b0;
                    w_wr_d       = w_pick_we;
                    if (r_grant != ID_DBG) w_rr_last_d = r_grant;
                end else begin
                    w_state_d = IDLE;
                    w_grant_d = ID_NONE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_grant_d = ID_NONE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_grant     <= ID_NONE;
            r_rr_last   <= ID_DA;
            r_lock_cnt  <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_mem_cs    <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_ack       <= 3'b000;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_grant     <= w_grant_d;
            r_rr_last   <= w_rr_last_d;
            r_lock_cnt  <= w_lock_cnt_d;
            r_we        <= w_we_d;
            r_mem_addr  <= w_addr_d;
            r_mem_wdata <= w_wdata_d;
            r_rdata     <= w_rdata_d;
            r_mem_cs    <= w_cs_d;
            r_mem_wr    <= w_wr_d;
            r_ack       <= w_ack_d;
            r_busy      <= (w_state_d != IDLE);
        end
    end

    // Memory data only arrives in the Ack cycle, so it is bypassed there and held afterwards.
    assign o_arb_rdata    = (r_state == RESP && !r_we) ? i_mem_rdata : r_rdata;
    assign o_if_ack       = r_ack[0];
    assign o_da_ack       = r_ack[1];
    assign o_dbg_ack      = r_ack[2];
    assign o_arb_grant_id = r_grant;
    assign o_arb_busy     = r_busy;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_mem_cs       = r_mem_cs;
    assign o_mem_wr       = r_mem_wr;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a synchronous byte-memory model;
// unwritten locations read back as (addr[7:0] ^ 8'hB5).
module tb_mem_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_lock, if_we, if_ack;
    logic [15:0] if_addr;
    logic [7:0]  if_wdata;
    logic        da_req, da_lock, da_we, da_ack;
    logic [15:0] da_addr;
    logic [7:0]  da_wdata;
    logic        dbg_req, dbg_lock, dbg_we, dbg_ack;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [7:0]  arb_rdata;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_cs, mem_wr;

    int checks;
    int errors;

    logic [7:0] mem [256];
    bit         mem_vld [256];

    mem_access_arbiter dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_if_req       (if_req),
        .i_if_lock      (if_lock),
        .i_if_we        (if_we),
        .i_if_addr      (if_addr),
        .i_if_wdata     (if_wdata),
        .o_if_ack       (if_ack),
        .i_da_req       (da_req),
        .i_da_lock      (da_lock),
        .i_da_we        (da_we),
        .i_da_addr      (da_addr),
        .i_da_wdata     (da_wdata),
        .o_da_ack       (da_ack),
        .i_dbg_req      (dbg_req),
        .i_dbg_lock     (dbg_lock),
        .i_dbg_we       (dbg_we),
        .i_dbg_addr     (dbg_addr),
        .i_dbg_wdata    (dbg_wdata),
        .o_dbg_ack      (dbg_ack),
        .o_arb_rdata    (arb_rdata),
        .o_arb_grant_id (grant_id),
        .o_arb_busy     (busy),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .o_mem_cs       (mem_cs),
        .o_mem_wr       (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_cs) begin
            if (mem_wr) begin
                mem[mem_addr[7:0]]     <= mem_wdata;
                mem_vld[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= mem_vld[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                                    : (mem_addr[7:0] ^ 8'hB5);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req  = 1'b0; if_lock  = 1'b0; if_we  = 1'b0; if_addr  = '0; if_wdata  = '0;
        da_req  = 1'b0; da_lock  = 1'b0; da_we  = 1'b0; da_addr  = '0; da_wdata  = '0;
        dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        checks++;
        if ({mem_cs, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b0, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_mem: got cs=%b wr=%b addr=%h wdata=%h expected 1 0 0000 00",
                     mem_cs, mem_wr, mem_addr, mem_wdata);
        end
        checks++;
        if ({if_ack, da_ack, dbg_ack, grant_id, busy, arb_rdata} !== 14'h0) begin
            errors++;
            $display("FAIL reset_ctl: got acks=%b%b%b grant=%0d busy=%b rdata=%h expected all 0",
                     if_ack, da_ack, dbg_ack, grant_id, busy, arb_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        checks++;
        if ({mem_cs, mem_wr, mem_addr} !== {1'b0, 1'b0, 16'h0010}) begin
            errors++;
            $display("FAIL rd_access: got cs=%b wr=%b addr=%h expected 0 0 0010", mem_cs, mem_wr, mem_addr);
        end
        checks++;
        if ({grant_id, busy, if_ack} !== {2'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rd_grant: got grant=%0d busy=%b ack=%b expected 1 1 0", grant_id, busy, if_ack);
        end
        tick();
        checks++;
        if ({if_ack, mem_cs} !== 2'b11) begin
            errors++;
            $display("FAIL rd_ack: got ack=%b cs=%b expected 1 1", if_ack, mem_cs);
        end
        checks++;
        if (arb_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_data: got %h expected a5", arb_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({if_ack, grant_id, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rd_idle: got ack=%b grant=%0d busy=%b expected 0 0 0", if_ack, grant_id, busy);
        end
        checks++;
        if (arb_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_hold: got %h expected a5", arb_rdata);
        end
    endtask

    task automatic test_locked_fetch();
        do_reset();
        if_req = 1'b1; if_lock = 1'b1; if_addr = 16'h0020;
        da_req = 1'b1; da_addr = 16'h0040;
        tick();
        checks++;
        if ({grant_id, mem_addr} !== {2'd1, 16'h0020}) begin
            errors++;
            $display("FAIL lk_beat1: got grant=%0d addr=%h expected 1 0020", grant_id, mem_addr);
        end
        tick();
        checks++;
        if ({if_ack, da_ack, arb_rdata} !== {1'b1, 1'b0, 8'h95}) begin
            errors++;
            $display("FAIL lk_ack1: got if=%b da=%b rdata=%h expected 1 0 95", if_ack, da_ack, arb_rdata);
        end
        if_addr = 16'h0021;
        tick();
        checks++;
        if ({grant_id, mem_cs, mem_addr, if_ack} !== {2'd1, 1'b0, 16'h0021, 1'b0}) begin
            errors++;
            $display("FAIL lk_beat2: got grant=%0d cs=%b addr=%h ack=%b expected 1 0 0021 0",
                     grant_id, mem_cs, mem_addr, if_ack);
        end
        if_lock = 1'b0;
        tick();
        checks++;
        if ({if_ack, da_ack, arb_rdata} !== {1'b1, 1'b0, 8'h94}) begin
            errors++;
            $display("FAIL lk_ack2: got if=%b da=%b rdata=%h expected 1 0 94", if_ack, da_ack, arb_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL lk_release: got grant=%0d expected 0", grant_id);
        end
        tick();
        checks++;
        if ({grant_id, mem_addr} !== {2'd2, 16'h0040}) begin
            errors++;
            $display("FAIL lk_da_grant: got grant=%0d addr=%h expected 2 0040", grant_id, mem_addr);
        end
        tick();
        checks++;
        if ({da_ack, arb_rdata} !== {1'b1, 8'hF5}) begin
            errors++;
            $display("FAIL lk_da_ack: got ack=%b rdata=%h expected 1 f5", da_ack, arb_rdata);
        end
        da_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [7];
        logic [1:0] got_id;
        bit         seen;
        exp_seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        do_reset();
        if_req   = 1'b1; if_addr  = 16'h0001;
        da_req   = 1'b1; da_addr  = 16'h0002;
        dbg_addr = 16'h0003;
        for (int b = 0; b < 7; b++) begin
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                tick();
                seen = if_ack | da_ack | dbg_ack;
            end
            got_id = 2'd0;
            if (if_ack) got_id = 2'd1;
            else if (da_ack) got_id = 2'd2;
            else if (dbg_ack) got_id = 2'd3;
            checks++;
            if (got_id !== exp_seq[b]) begin
                errors++;
                $display("FAIL cont_beat%0d: got acked id=%0d expected %0d", b, got_id, exp_seq[b]);
            end
            if (b == 3) dbg_req = 1'b1;
            if (dbg_ack) dbg_req = 1'b0;
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_lock_limit();
        int da_acks;
        int da_at_dbg;
        bit got_dbg;
        logic [1:0] grant_at_dbg;
        do_reset();
        da_req = 1'b1; da_lock = 1'b1; da_addr = 16'h0080;
        tick();
        dbg_req = 1'b1; dbg_addr = 16'h0090;
        da_acks = 0; da_at_dbg = -1; got_dbg = 1'b0; grant_at_dbg = 2'd0;
        for (int c = 0; c < 40 && !got_dbg; c++) begin
            tick();
            if (da_ack) da_acks++;
            if (dbg_ack) begin
                got_dbg      = 1'b1;
                da_at_dbg    = da_acks;
                grant_at_dbg = grant_id;
            end
        end
        checks++;
        if (!got_dbg) begin
            errors++;
            $display("FAIL lim_dbg_served: got no DBG ack within 40 cycles expected one");
        end
        checks++;
        if (da_at_dbg != 4) begin
            errors++;
            $display("FAIL lim_da_count: got %0d DA acks before DBG expected 4", da_at_dbg);
        end
        checks++;
        if (grant_at_dbg !== 2'd3) begin
            errors++;
            $display("FAIL lim_dbg_grant: got grant=%0d expected 3", grant_at_dbg);
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_write();
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        tick();
        if_req = 1'b0;
        tick();
        da_req = 1'b1; da_we = 1'b1; da_addr = 16'h00FF; da_wdata = 8'h3C;
        tick();
        checks++;
        if ({mem_cs, mem_wr, mem_addr, mem_wdata} !== {1'b0, 1'b1, 16'h00FF, 8'h3C}) begin
            errors++;
            $display("FAIL wr_access: got cs=%b wr=%b addr=%h wdata=%h expected 0 1 00ff 3c",
                     mem_cs, mem_wr, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if ({da_ack, mem_cs, mem_wr} !== 3'b110) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b cs=%b wr=%b expected 1 1 0", da_ack, mem_cs, mem_wr);
        end
        checks++;
        if (arb_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_rdata_ack: got %h expected a5", arb_rdata);
        end
        da_req = 1'b0; da_we = 1'b0;
        tick();
        checks++;
        if (arb_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_rdata_hold: got %h expected a5", arb_rdata);
        end
        dbg_req = 1'b1; dbg_addr = 16'h00FF;
        tick();
        tick();
        checks++;
        if ({dbg_ack, arb_rdata} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL wr_readback: got ack=%b rdata=%h expected 1 3c", dbg_ack, arb_rdata);
        end
        dbg_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_in_access();
        do_reset();
        if_req = 1'b1; if_addr = 16'h0033;
        tick();
        checks++;
        if (mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL rsta_pre: got cs=%b expected 0", mem_cs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_cs, if_ack, grant_id, busy} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rsta_async: got cs=%b ack=%b grant=%0d busy=%b expected 1 0 0 0",
                     mem_cs, if_ack, grant_id, busy);
        end
        if_req = 1'b0;
        repeat (2) tick();
        checks++;
        if ({if_ack, mem_cs} !== 2'b01) begin
            errors++;
            $display("FAIL rsta_noack: got ack=%b cs=%b expected 0 1", if_ack, mem_cs);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, grant_id} !== 3'b000) begin
            errors++;
            $display("FAIL rsta_idle: got busy=%b grant=%0d expected 0 0", busy, grant_id);
        end
        if_req = 1'b1;
        tick();
        checks++;
        if ({mem_cs, mem_addr} !== {1'b0, 16'h0033}) begin
            errors++;
            $display("FAIL rsta_new_access: got cs=%b addr=%h expected 0 0033", mem_cs, mem_addr);
        end
        tick();
        checks++;
        if ({if_ack, arb_rdata} !== {1'b1, 8'h86}) begin
            errors++;
            $display("FAIL rsta_new_ack: got ack=%b rdata=%h expected 1 86", if_ack, arb_rdata);
        end
        if_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        mem_rdata = 8'h00;
        clear_inputs();
        test_reset();
        test_single_read();
        test_locked_fetch();
        test_contention();
        test_lock_limit();
        test_write();
        test_reset_in_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
